pe_result_buffer: RTL



---
 rtl/pe_result_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pe_result_buffer.sv
// Result capture, DOT reduction and store drain
// for the SIMD PE array.
module pe_result_buffer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [3:0]              opcode,
    input  logic [LANES*DATA_W-1:0] pe_out,
    output logic                    st_valid,
    input  logic                    st_ready,
    output logic [DATA_W-1:0]       st_data,
    output logic                    st_last,
    output logic [DATA_W-1:0]       dot_sum,
    output logic                    err,
    output logic                    done
);

    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DOT  = 4'd6;
    localparam logic [3:0] OP_BUF1 = 4'd7;
    localparam logic [3:0] OP_BUF2 = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;
    localparam logic [3:0] OP_STOP = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        HALT
    } state_t;

    state_t state;

    logic [LANES-1:0][DATA_W-1:0] res_q;
    logic [LANES-1:0][DATA_W-1:0] buf1;
    logic [LANES-1:0][DATA_W-1:0] buf2;
    logic                         res_vld;
    logic                         buf1_vld;
    logic                         buf2_vld;
    logic [DATA_W-1:0]            dot_acc;
    logic [IW-1:0]                idx;
    logic                         sel;
    logic [DATA_W-1:0]            lane_sum;
    logic [DATA_W-1:0]            dot_next;
    logic                         final_beat;

    // Sum of all lanes, wrapping at DATA_W bits.
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + pe_out[i*DATA_W +: DATA_W];
        end
        dot_next = dot_acc + lane_sum;
    end

    // Stream outputs derive directly from registered drain state.
    always_comb begin
        st_valid   = (state == DRAIN);
        st_data    = '0;
        final_beat = (idx == LAST_IDX) && (sel || !buf2_vld);
        if (st_valid) begin
            st_data = sel ? buf2[idx] : buf1[idx];
        end
        st_last  = st_valid && final_beat;
        op_ready = (state == IDLE);
        dot_sum  = dot_acc;
    end

    // Control FSM with result, buffer and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            res_q    <= '0;
            buf1     <= '0;
            buf2     <= '0;
            res_vld  <= 1'b0;
            buf1_vld <= 1'b0;
            buf2_vld <= 1'b0;
            dot_acc  <= '0;
            idx      <= '0;
            sel      <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        case (opcode)
                            OP_ADD, OP_SUB, OP_MUL: begin
                                res_q   <= pe_out;
                                res_vld <= 1'b1;
                                dot_acc <= '0;
                            end
                            OP_DOT: begin
                                dot_acc  <= dot_next;
                                res_q    <= '0;
                                res_q[0] <= dot_next;
                                res_vld  <= 1'b1;
                            end
                            OP_BUF1: begin
                                dot_acc <= '0;
                                if (res_vld) begin
                                    buf1     <= res_q;
                                    buf1_vld <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            OP_BUF2: begin
                                dot_acc <= '0;
                                if (res_vld) begin
                                    buf2     <= res_q;
                                    buf2_vld <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            OP_STORE: begin
                                if (buf1_vld || buf2_vld) begin
                                    state <= DRAIN;
                                    idx   <= '0;
                                    sel   <= !buf1_vld;
                                end
                            end
                            OP_STOP: begin
                                done  <= 1'b1;
                                state <= HALT;
                            end
                            default: ;
                        endcase
                    end
                end
                DRAIN: begin
                    if (st_ready) begin
                        if (final_beat) begin
                            buf1_vld <= 1'b0;
                            buf2_vld <= 1'b0;
                            idx      <= '0;
                            sel      <= 1'b0;
                            state    <= IDLE;
                        end else if (idx == LAST_IDX) begin
                            idx <= '0;
                            sel <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
